// File: rtl/int_to_fp_arbiter.sv
// Two-requester round-robin front end for one shared 8-bit int -> 13-bit fp converter.
// The request is captured in IDLE, the conversion result is registered in CONV, and valid pulses after that.
module int_to_fp (
    input  logic [7:0]  int_in,
    output logic [12:0] fp
);
    logic [7:0] mag;
    logic [3:0] exp;
    logic [7:0] frac;

    always_comb begin
        // -128 negates to 8'h80, which is still the correct unsigned magnitude
        mag = int_in[7] ? 8'(~int_in + 8'd1) : int_in;
        exp = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (mag[i]) exp = 4'(i + 1);
        end
        frac = mag << (4'd8 - exp);
        fp   = {int_in[7], exp, frac};
    end
endmodule

module int_to_fp_arbiter #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [7:0]  int0,
    input  logic        req1,
    input  logic [7:0]  int1,
    output logic        grant0,
    output logic        grant1,
    output logic [12:0] fp_out,
    output logic        valid,
    output logic        src
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        prio_q, prio_d;
    logic [7:0]  op_q, op_d;
    logic        src_reg_q, src_reg_d;
    logic        grant0_q, grant0_d;
    logic        grant1_q, grant1_d;
    logic        valid_q, valid_d;
    logic [12:0] fp_q, fp_d;
    logic        src_q, src_d;
    logic        winner;
    logic [12:0] conv_fp;

    int_to_fp u_conv (
        .int_in (op_q),
        .fp     (conv_fp)
    );

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        op_d      = op_q;
        src_reg_d = src_reg_q;
        grant0_d  = 1'b0;
        grant1_d  = 1'b0;
        valid_d   = 1'b0;
        fp_d      = fp_q;
        src_d     = src_q;
        winner    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // prio only matters when both ask; a lone requester always wins
                    winner    = (req0 && req1) ? prio_q : req1;
                    op_d      = winner ? int1 : int0;
                    src_reg_d = winner;
                    grant0_d  = ~winner;
                    grant1_d  = winner;
                    prio_d    = ~winner;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                fp_d    = conv_fp;
                src_d   = src_reg_q;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            prio_q    <= PRIO_INIT;
            op_q      <= 8'd0;
            src_reg_q <= 1'b0;
            grant0_q  <= 1'b0;
            grant1_q  <= 1'b0;
            valid_q   <= 1'b0;
            fp_q      <= 13'd0;
            src_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            op_q      <= op_d;
            src_reg_q <= src_reg_d;
            grant0_q  <= grant0_d;
            grant1_q  <= grant1_d;
            valid_q   <= valid_d;
            fp_q      <= fp_d;
            src_q     <= src_d;
        end
    end

    assign grant0 = grant0_q;
    assign grant1 = grant1_q;
    assign valid  = valid_q;
    assign fp_out = fp_q;
    assign src    = src_q;
endmodule

// File: tb/tb_int_to_fp_arbiter.sv
// Bench for int_to_fp_arbiter: single-job vector table, hand sequences for contention and
// reset during conversion, full operand sweep, and a randomized run against a transaction model.
module tb_int_to_fp_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [7:0]  int0, int1;
    logic        grant0, grant1, valid, src;
    logic [12:0] fp_out;

    int checks = 0;
    int errors = 0;

    int_to_fp_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .int0   (int0),
        .req1   (req1),
        .int1   (int1),
        .grant0 (grant0),
        .grant1 (grant1),
        .fp_out (fp_out),
        .valid  (valid),
        .src    (src)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        r0;
        logic [7:0]  i0;
        logic        r1;
        logic [7:0]  i1;
        logic [1:0]  g;
        logic [12:0] fp;
        logic        s;
    } vec_t;

    vec_t vecs [7];

    // Reference conversion from the number format's definition
    function automatic logic [12:0] ref_fp(input logic [7:0] v);
        int s, m, e, f;
        s = int'($signed(v));
        m = (s < 0) ? -s : s;
        e = $clog2(m + 1);
        f = (m << (8 - e)) & 255;
        return {(s < 0) ? 1'b1 : 1'b0, 4'(e), 8'(f)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; int0 = 8'd0; int1 = 8'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    // One job from IDLE: grant the cycle after sampling, valid the cycle after that, fp held afterwards
    task automatic do_job(input logic r0, input logic [7:0] i0, input logic r1, input logic [7:0] i1,
                          input logic [1:0] eg, input logic [12:0] efp, input logic es, input string nm);
        req0 = r0; int0 = i0; req1 = r1; int1 = i1;
        step();
        chk({nm, "_grant"}, {30'd0, grant1, grant0}, {30'd0, eg});
        chk({nm, "_novalid"}, {31'd0, valid}, 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        step();
        chk({nm, "_valid"}, {31'd0, valid}, 32'd1);
        chk({nm, "_fp"}, {19'd0, fp_out}, {19'd0, efp});
        chk({nm, "_src"}, {31'd0, src}, {31'd0, es});
        chk({nm, "_grant_off"}, {30'd0, grant1, grant0}, 32'd0);
        step();
        chk({nm, "_valid_off"}, {31'd0, valid}, 32'd0);
        chk({nm, "_fp_hold"}, {19'd0, fp_out}, {19'd0, efp});
    endtask

    // Randomized run state
    logic [1:0]  pred_g, nxt_g;
    logic        pred_v, nxt_v;
    logic [7:0]  pred_op, nxt_op, gop;
    logic        pred_s, nxt_s;
    logic        m_prio, w;

    initial begin
        vecs[0] = '{1'b1, 8'd1,   1'b0, 8'd0,   2'b01, 13'b0_0001_1000_0000, 1'b0};
        vecs[1] = '{1'b0, 8'd0,   1'b1, 8'h80,  2'b10, 13'b1_1000_1000_0000, 1'b1};
        vecs[2] = '{1'b0, 8'd0,   1'b1, 8'd0,   2'b10, 13'h0000,             1'b1};
        vecs[3] = '{1'b1, 8'd5,   1'b1, 8'hFD,  2'b01, 13'b0_0011_1010_0000, 1'b0};
        vecs[4] = '{1'b1, 8'd7,   1'b1, 8'hFF,  2'b10, 13'b1_0001_1000_0000, 1'b1};
        vecs[5] = '{1'b0, 8'd0,   1'b1, 8'h7F,  2'b10, 13'b0_0111_1111_1110, 1'b1};
        vecs[6] = '{1'b1, 8'hC0,  1'b1, 8'd3,   2'b01, 13'b1_0111_1000_0000, 1'b0};

        do_reset();
        chk("rst_grant", {30'd0, grant1, grant0}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_fp", {19'd0, fp_out}, 32'd0);
        chk("rst_src", {31'd0, src}, 32'd0);

        for (int k = 0; k < 7; k++)
            do_job(vecs[k].r0, vecs[k].i0, vecs[k].r1, vecs[k].i1,
                   vecs[k].g, vecs[k].fp, vecs[k].s, $sformatf("vec%0d", k));

        // Both held high: grants alternate 0,1,0,1 two cycles apart
        do_reset();
        req0 = 1'b1; int0 = 8'h11; req1 = 1'b1; int1 = 8'hF0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k % 2 == 1) begin
                chk($sformatf("rr_grant%0d", k), {30'd0, grant1, grant0},
                    ((k / 2) % 2 == 0) ? 32'd1 : 32'd2);
                chk($sformatf("rr_novalid%0d", k), {31'd0, valid}, 32'd0);
            end else begin
                chk($sformatf("rr_idle%0d", k), {30'd0, grant1, grant0}, 32'd0);
                chk($sformatf("rr_valid%0d", k), {31'd0, valid}, 32'd1);
                chk($sformatf("rr_src%0d", k), {31'd0, src}, ((k / 2 - 1) % 2 == 0) ? 32'd0 : 32'd1);
                chk($sformatf("rr_fp%0d", k), {19'd0, fp_out},
                    {19'd0, ((k / 2 - 1) % 2 == 0) ? ref_fp(8'h11) : ref_fp(8'hF0)});
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Reset while converting: no valid, fp cleared, next job normal
        do_reset();
        req0 = 1'b1; int0 = 8'd9;
        step();
        chk("mid_grant", {30'd0, grant1, grant0}, 32'd1);
        req0 = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_novalid", {31'd0, valid}, 32'd0);
        chk("mid_fp", {19'd0, fp_out}, 32'd0);
        step();
        chk("mid_novalid2", {31'd0, valid}, 32'd0);
        do_job(1'b0, 8'd0, 1'b1, 8'd2, 2'b10, ref_fp(8'd2), 1'b1, "post_rst");

        // Full operand sweep on requester 0
        for (int v = 0; v < 256; v++)
            do_job(1'b1, 8'(v), 1'b0, 8'd0, 2'b01, ref_fp(8'(v)), 1'b0, $sformatf("sweep%0d", v));

        // Randomized producers against a transaction-level model
        do_reset();
        pred_g = 2'b00; pred_v = 1'b0; pred_op = 8'd0; pred_s = 1'b0; m_prio = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!req0 && $urandom_range(0, 2) == 0) begin req0 = 1'b1; int0 = 8'($urandom); end
            if (!req1 && $urandom_range(0, 2) == 0) begin req1 = 1'b1; int1 = 8'($urandom); end
            nxt_v = (pred_g != 2'b00);
            nxt_op = pred_op; nxt_s = pred_s;
            nxt_g = 2'b00;
            if (pred_g == 2'b00 && (req0 || req1)) begin
                w = (req0 && req1) ? m_prio : req1;
                nxt_g = w ? 2'b10 : 2'b01;
                gop = w ? int1 : int0;
                m_prio = ~w;
                nxt_op = gop; nxt_s = w;
            end
            step();
            chk("rnd_grant", {30'd0, grant1, grant0}, {30'd0, nxt_g});
            chk("rnd_valid", {31'd0, valid}, {31'd0, nxt_v});
            if (nxt_v) begin
                chk("rnd_fp", {19'd0, fp_out}, {19'd0, ref_fp(pred_op)});
                chk("rnd_src", {31'd0, src}, {31'd0, pred_s});
            end
            pred_g = nxt_g; pred_v = nxt_v; pred_op = nxt_op; pred_s = nxt_s;
            if (nxt_g[0]) req0 = 1'b0;
            if (nxt_g[1]) req1 = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
